// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pack
// Shared types and constants for the fetch sequencer:
//   fetch_state_t  : sequencer state (IDLE, RUN, HALT, FAULT)
//   fault_t        : 2-bit fault code reported on fault_code
//   SUB_VEC_P1..P3 : per-program subroutine entry points, 16 x 10-bit each,
//                    indexed by call_idx. Zero entries are unused vectors.
// No ports (package).
// -----------------------------------------------------------------------------
package fetch_pack;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    FLT_NONE      = 2'b00,
    FLT_OVERFLOW  = 2'b01,
    FLT_UNDERFLOW = 2'b10
  } fault_t;

  localparam int SUB_W = 10;

  localparam logic [SUB_W-1:0] SUB_VEC_P1 [16] = '{
    10'd64,  10'd128, 10'd192, 10'd256, 10'd0, 10'd0, 10'd0, 10'd0,
    10'd0,   10'd0,   10'd0,   10'd0,   10'd0, 10'd0, 10'd0, 10'd0
  };

  localparam logic [SUB_W-1:0] SUB_VEC_P2 [16] = '{
    10'd32,  10'd96,  10'd160, 10'd224, 10'd288, 10'd352, 10'd0, 10'd0,
    10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   10'd0, 10'd0
  };

  localparam logic [SUB_W-1:0] SUB_VEC_P3 [16] = '{
    10'd100, 10'd200, 10'd300, 10'd400, 10'd512, 10'd640, 10'd768, 10'd1020,
    10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   10'd0
  };

endpackage

// File: rtl/sub_vector_table.sv
// -----------------------------------------------------------------------------
// sub_vector_table
// Combinational subroutine vector lookup. The PROGRAM parameter picks which
// vector set is used, matching the program loaded in instruction memory.
// Unknown PROGRAM values and unused indices yield address 0.
// Ports:
//   call_idx  in  4      subroutine index from the decoder
//   sub_addr  out SUB_W  subroutine entry address
// -----------------------------------------------------------------------------
module sub_vector_table
  import fetch_pack::*;
#(
  parameter int PROGRAM = 3
) (
  input  logic [3:0]       call_idx,
  output logic [SUB_W-1:0] sub_addr
);

  always_comb begin
    sub_addr = '0;
    case (PROGRAM)
      1:       sub_addr = SUB_VEC_P1[call_idx];
      2:       sub_addr = SUB_VEC_P2[call_idx];
      3:       sub_addr = SUB_VEC_P3[call_idx];
      default: sub_addr = '0;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// PC generator feeding instruction memory. One instruction per cycle, no delay
// slots. Supports sequential fetch, absolute branch, forward skip, subroutine
// call/return through a hardware return stack, and halt.
// Optional feature: define FETCH_PERF_EN to add the cycle_cnt / instr_cnt
// performance counters (saturating, frozen outside RUN).
// Ports:
//   clk, rst_n             clock (rising edge), synchronous active-low reset
//   start                  leave IDLE, begin fetch at pc 0
//   stall                  freeze pc, stack and state this cycle
//   br_taken, br_target    absolute branch to zero-extended br_target
//   skip_taken, skip_off   skip skip_off instructions past pc+1
//   call, call_idx         push pc+1, jump to subroutine vector
//   ret                    pop return address
//   halt                   stop fetching
//   pc                     fetch address
//   running/halted/fault   state decodes
//   fault_code             00 none, 01 overflow, 10 underflow
//   depth                  return-stack occupancy
//   cycle_cnt, instr_cnt   (FETCH_PERF_EN only) RUN cycles / unstalled RUN cycles
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_pack::*;
#(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 4,
  parameter int PROGRAM     = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               stall,
  input  logic                               br_taken,
  input  logic [7:0]                         br_target,
  input  logic                               skip_taken,
  input  logic [2:0]                         skip_off,
  input  logic                               call,
  input  logic [3:0]                         call_idx,
  input  logic                               ret,
  input  logic                               halt,
  output logic [PC_W-1:0]                    pc,
  output logic                               running,
  output logic                               halted,
  output logic                               fault,
  output logic [1:0]                         fault_code,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]                        cycle_cnt,
  output logic [15:0]                        instr_cnt
`endif
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH+1);

  fetch_state_t            state_q, state_d;
  fault_t                  fault_code_q, fault_code_d;
  logic [PC_W-1:0]         pc_q, pc_d;
  logic [DEPTH_W-1:0]      depth_q, depth_d;
  logic [PC_W-1:0]         stack_q [STACK_DEPTH];
  logic [PC_W-1:0]         stack_d [STACK_DEPTH];

  logic [SUB_W-1:0]        sub_addr;
  logic [PC_W-1:0]         pc_inc;
  logic [PC_W-1:0]         pc_skip;
  logic [PC_W-1:0]         stack_top;

  sub_vector_table #(
    .PROGRAM (PROGRAM)
  ) u_sub_vector_table (
    .call_idx (call_idx),
    .sub_addr (sub_addr)
  );

  // Natural PC_W-bit adders give the required modulo-2**PC_W wrap.
  assign pc_inc  = pc_q + PC_W'(1);
  assign pc_skip = pc_inc + PC_W'(skip_off);

  // Top-of-stack read: entry depth_q-1. A compare loop avoids an index
  // wider than the array when DEPTH_W exceeds log2(STACK_DEPTH).
  always_comb begin
    stack_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (DEPTH_W'(i + 1) == depth_q) stack_top = stack_q[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    pc_d         = pc_q;
    depth_d      = depth_q;
    stack_d      = stack_q;

    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (!stall) begin
          if (halt) begin
            state_d = HALT;
          end else if (ret) begin
            if (depth_q == '0) begin
              state_d      = FAULT;
              fault_code_d = FLT_UNDERFLOW;
            end else begin
              pc_d    = stack_top;
              depth_d = depth_q - DEPTH_W'(1);
            end
          end else if (call) begin
            if (depth_q == DEPTH_W'(STACK_DEPTH)) begin
              state_d      = FAULT;
              fault_code_d = FLT_OVERFLOW;
            end else begin
              for (int i = 0; i < STACK_DEPTH; i++) begin
                if (DEPTH_W'(i) == depth_q) stack_d[i] = pc_inc;
              end
              pc_d    = PC_W'(sub_addr);
              depth_d = depth_q + DEPTH_W'(1);
            end
          end else if (br_taken) begin
            pc_d = PC_W'(br_target);
          end else if (skip_taken) begin
            pc_d = pc_skip;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      default: ;  // HALT and FAULT hold until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fault_code_q <= FLT_NONE;
      pc_q         <= '0;
      depth_q      <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      fault_code_q <= fault_code_d;
      pc_q         <= pc_d;
      depth_q      <= depth_d;
      stack_q      <= stack_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] cycle_cnt_q, cycle_cnt_d;
  logic [15:0] instr_cnt_q, instr_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (state_q == RUN) begin
      if (cycle_cnt_q != 16'hFFFF) cycle_cnt_d = cycle_cnt_q + 16'd1;
      if (!stall && instr_cnt_q != 16'hFFFF) instr_cnt_d = instr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

  assign pc         = pc_q;
  assign running    = (state_q == RUN);
  assign halted     = (state_q == HALT);
  assign fault      = (state_q == FAULT);
  assign fault_code = fault_code_q;
  assign depth      = depth_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed scenarios followed by randomized control traffic, every cycle
// compared against a queue-based reference model of the fetch sequencer.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int PC_W        = 10;
  localparam int STACK_DEPTH = 4;
  localparam int PROGRAM     = 3;
  localparam int DEPTH_W     = $clog2(STACK_DEPTH+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, start, stall, br_taken, skip_taken, call, ret, halt;
  logic [7:0]         br_target;
  logic [2:0]         skip_off;
  logic [3:0]         call_idx;
  logic [PC_W-1:0]    pc;
  logic               running, halted, fault;
  logic [1:0]         fault_code;
  logic [DEPTH_W-1:0] depth;
`ifdef FETCH_PERF_EN
  logic [15:0]        cycle_cnt, instr_cnt;
`endif

  fetch_sequencer #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH),
    .PROGRAM     (PROGRAM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .skip_taken (skip_taken),
    .skip_off   (skip_off),
    .call       (call),
    .call_idx   (call_idx),
    .ret        (ret),
    .halt       (halt),
    .pc         (pc),
    .running    (running),
    .halted     (halted),
    .fault      (fault),
    .fault_code (fault_code),
    .depth      (depth)
`ifdef FETCH_PERF_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 run, 2 halt, 3 fault.
  int m_pc;
  int m_stack[$];
  int m_mode;
  int m_code;
  int m_cyc;
  int m_ins;

  function automatic int sub_of(int idx);
    case (idx)
      0: return 100;
      1: return 200;
      2: return 300;
      3: return 400;
      4: return 512;
      5: return 640;
      6: return 768;
      7: return 1020;
      default: return 0;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_pc = 0; m_stack.delete(); m_mode = 0; m_code = 0; m_cyc = 0; m_ins = 0;
    end else begin
      case (m_mode)
        0: if (start) m_mode = 1;
        1: begin
          if (m_cyc < 65535) m_cyc++;
          if (!stall) begin
            if (m_ins < 65535) m_ins++;
            if (halt) m_mode = 2;
            else if (ret) begin
              if (m_stack.size() == 0) begin m_mode = 3; m_code = 2; end
              else m_pc = m_stack.pop_back();
            end else if (call) begin
              if (m_stack.size() == STACK_DEPTH) begin m_mode = 3; m_code = 1; end
              else begin
                m_stack.push_back((m_pc + 1) % 1024);
                m_pc = sub_of(int'(call_idx));
              end
            end else if (br_taken) m_pc = int'(br_target);
            else if (skip_taken) m_pc = (m_pc + 1 + int'(skip_off)) % 1024;
            else m_pc = (m_pc + 1) % 1024;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    chk("pc",         32'(pc),         32'(m_pc));
    chk("running",    32'(running),    32'(m_mode == 1));
    chk("halted",     32'(halted),     32'(m_mode == 2));
    chk("fault",      32'(fault),      32'(m_mode == 3));
    chk("fault_code", 32'(fault_code), 32'(m_code));
    chk("depth",      32'(depth),      32'(m_stack.size()));
`ifdef FETCH_PERF_EN
    chk("cycle_cnt",  32'(cycle_cnt),  32'(m_cyc));
    chk("instr_cnt",  32'(instr_cnt),  32'(m_ins));
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic clear();
    start = 0; stall = 0; br_taken = 0; br_target = '0; skip_taken = 0;
    skip_off = '0; call = 0; call_idx = '0; ret = 0; halt = 0;
  endtask

  task automatic restart();
    clear();
    rst_n = 0; step();
    rst_n = 1; start = 1; step();
    start = 0;
  endtask

  task automatic do_br(int t);
    br_taken = 1; br_target = 8'(t); step(); br_taken = 0;
  endtask

  task automatic do_call(int idx);
    call = 1; call_idx = 4'(idx); step(); call = 0;
  endtask

  initial begin
    clear();
    rst_n = 0;

    // Reset state
    step(); step();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);

    // Start at cycle 2, sequential fetch 0,1,2,3
    rst_n = 1; step();
    start = 1; step(); start = 0;
    chk("run_first_pc", 32'(pc), 32'd0);
    chk("run_running", 32'(running), 32'd1);
    step(); chk("seq_pc1", 32'(pc), 32'd1);
    step(); chk("seq_pc2", 32'(pc), 32'd2);
    step(); chk("seq_pc3", 32'(pc), 32'd3);
    repeat (6) step();
    chk("seq_pc9", 32'(pc), 32'd9);

    // Branch and skip
    do_br(15); chk("br_pc15", 32'(pc), 32'd15);
    do_br(20);
    skip_taken = 1; skip_off = 3'd3; step(); skip_taken = 0;
    chk("skip_pc24", 32'(pc), 32'd24);

    // Call / return, call beats branch
    do_br(19);
    do_call(1);
    chk("call_pc", 32'(pc), 32'd200);
    chk("call_depth", 32'(depth), 32'd1);
    ret = 1; step(); ret = 0;
    chk("ret_pc", 32'(pc), 32'd20);
    chk("ret_depth", 32'(depth), 32'd0);
    br_taken = 1; br_target = 8'd77; do_call(2); br_taken = 0;
    chk("call_prio_pc", 32'(pc), 32'd300);
    ret = 1; step(); ret = 0;
    chk("ret2_pc", 32'(pc), 32'd21);

    // Stall at pc 40 with a branch request that must be ignored
    do_br(40);
    stall = 1; br_taken = 1; br_target = 8'd99;
    step(); chk("stall_pc_a", 32'(pc), 32'd40);
    step(); chk("stall_pc_b", 32'(pc), 32'd40);
    step(); chk("stall_pc_c", 32'(pc), 32'd40);
    clear(); step();
    chk("post_stall_pc", 32'(pc), 32'd41);

    // Return address wrap: call from 1023 pushes 0
    do_call(7);
    repeat (3) step();
    chk("pc1023", 32'(pc), 32'd1023);
    do_call(0);
    chk("depth2", 32'(depth), 32'd2);
    ret = 1; step();
    chk("ret_wrap_pc", 32'(pc), 32'd0);
    step(); ret = 0;
    chk("ret_outer_pc", 32'(pc), 32'd42);

    // Sequential wrap 1023 -> 0
    do_call(7);
    repeat (3) step();
    step();
    chk("seq_wrap_pc", 32'(pc), 32'd0);
    ret = 1; step(); ret = 0;
    chk("ret_after_wrap", 32'(pc), 32'd43);

    // Reset mid-call with depth 2 and pending stall
    do_call(1); do_call(2);
    chk("mid_depth", 32'(depth), 32'd2);
    rst_n = 0; call = 1; stall = 1; step();
    chk("midrst_pc", 32'(pc), 32'd0);
    chk("midrst_depth", 32'(depth), 32'd0);
    chk("midrst_running", 32'(running), 32'd0);
    clear(); rst_n = 1; step();
    chk("midrst_idle", 32'(running), 32'd0);

    // Overflow on fifth nested call
    start = 1; step(); start = 0;
    repeat (5) do_call(1);
    chk("ovf_fault", 32'(fault), 32'd1);
    chk("ovf_code", 32'(fault_code), 32'd1);
    chk("ovf_pc", 32'(pc), 32'd200);
    start = 1; br_taken = 1; br_target = 8'd5; step(); clear();
    chk("ovf_sticky_pc", 32'(pc), 32'd200);
    chk("ovf_sticky", 32'(fault), 32'd1);

    // Underflow on ret at depth 0
    restart();
    ret = 1; step(); ret = 0;
    chk("unf_code", 32'(fault_code), 32'd2);
    chk("unf_pc", 32'(pc), 32'd0);

    // Halt at pc 50, start ignored afterwards
    restart();
    do_br(50);
    halt = 1; step(); halt = 0;
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", 32'(pc), 32'd50);
    start = 1; br_taken = 1; br_target = 8'd3; step(); clear();
    chk("halt_sticky_pc", 32'(pc), 32'd50);
    chk("halt_not_run", 32'(running), 32'd0);

`ifdef FETCH_PERF_EN
    // Stalled cycles excluded from instr_cnt
    restart();
    stall = 1; repeat (3) step(); stall = 0;
    repeat (2) step();
    chk("perf_cycles", 32'(cycle_cnt), 32'd5);
    chk("perf_instrs", 32'(instr_cnt), 32'd2);
`endif

    // Randomized traffic
    for (int seg = 0; seg < 15; seg++) begin
      restart();
      for (int n = 0; n < 150; n++) begin
        rst_n      = ($urandom_range(0, 149) != 0);
        start      = ($urandom_range(0, 1) == 0);
        stall      = ($urandom_range(0, 9) == 0);
        halt       = ($urandom_range(0, 199) == 0);
        ret        = ($urandom_range(0, 6) == 0);
        call       = ($urandom_range(0, 5) == 0);
        br_taken   = ($urandom_range(0, 5) == 0);
        skip_taken = ($urandom_range(0, 4) == 0);
        br_target  = 8'($urandom);
        skip_off   = 3'($urandom);
        call_idx   = 4'($urandom);
        step();
      end
    end
    clear(); rst_n = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- PC-generation stage directly upstream of instruction memory: drives the 10-bit pc that indexes the program store.
- Control inputs come from the decoder, which sees the fetched instruction.
- Implements sequential fetch, absolute branch (bnzr), forward skip (jizr), jump-to-subroutine (jtsr) with a hardware return stack, return (rfsr), and halt (done).
- One instruction per cycle, no delay slots.

Parameters:
- PC_W, 10, pc width; all pc arithmetic is modulo 2**PC_W.
- STACK_DEPTH, 4, return-stack entries (1..8).
- PROGRAM, 3, selects the subroutine vector set in sub_vector_table; matches the program-select value used by instruction memory.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  pulse; leaves IDLE and begins fetch at pc 0.
- stall  in  1  freezes pc, stack and state this cycle.
- br_taken  in  1  bnzr with a nonzero tested register.
- br_target  in  8  z register value; zero-extended absolute target.
- skip_taken  in  1  jizr with a zero tested register.
- skip_off  in  3  number of instructions to skip.
- call  in  1  jtsr.
- call_idx  in  4  subroutine index.
- ret  in  1  rfsr.
- halt  in  1  func done.
- pc  out  PC_W  fetch address to instruction memory.
- running  out  1  state is RUN.
- halted  out  1  state is HALT.
- fault  out  1  state is FAULT.
- fault_code  out  2  00 none, 01 stack overflow, 10 stack underflow.
- depth  out  $clog2(STACK_DEPTH+1)  current return-stack occupancy.

Behaviour:
- Reset: rst_n low at a rising edge clears all state.
  - pc=0, state=IDLE, depth=0, stack contents=0, fault_code=00.
  - Takes priority over everything, including mid-call and a pending stall.
- States: IDLE, RUN, HALT, FAULT.
  - IDLE->RUN when start=1; pc stays 0, so instruction 0 is fetched in the first RUN cycle.
  - RUN->HALT on halt.
  - RUN->FAULT on overflow or underflow.
  - HALT and FAULT are sticky until reset; start is ignored outside IDLE.
- In RUN with stall=0, next pc is chosen by fixed priority:
  1. halt: pc holds.
  2. ret:
     - depth=0 -> FAULT, code 10, pc holds.
     - otherwise pc=top of stack, depth-1.
  3. call:
     - depth=STACK_DEPTH -> FAULT, code 01, pc holds.
     - otherwise push pc+1, pc=sub_addr(call_idx), depth+1.
  4. br_taken: pc={2'b00, br_target}.
  5. skip_taken: pc=pc+1+skip_off.
  6. Otherwise pc=pc+1.
- Lower-priority requests asserted in the same cycle are discarded.
- Arithmetic: pc+1 and pc+1+skip_off wrap at 2**PC_W (1023+1 -> 0). The pushed return address also wraps.
- stall=1 in RUN: no change to pc, stack, depth or state; control inputs are ignored.
- Control inputs are ignored in IDLE, HALT and FAULT.
- Outputs are all registered or decoded directly from state; next pc is visible one cycle after the control input is sampled.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined: adds outputs cycle_cnt[15:0] and instr_cnt[15:0].
  - cycle_cnt counts RUN cycles.
  - instr_cnt counts RUN cycles with stall=0.
  - Both saturate at 16'hFFFF, clear on reset, and freeze in HALT/FAULT.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pack holds:
  - fetch_state_t enum (IDLE, RUN, HALT, FAULT).
  - fault_t enum with the 2-bit fault codes.
  - Per-program subroutine vector constants: SUB_VEC_P1, SUB_VEC_P2, SUB_VEC_P3 (each 16 x 10-bit).
- Sub-module sub_vector_table: combinational lookup, call_idx -> sub_addr, selected by PROGRAM.
  - Unused indices return 0.
- The return stack stays inline as a register array plus pointer.

Test Plan:
- Reset, start at cycle 2, no control -> pc 0,1,2,3 on successive RUN cycles; running=1.
- pc=9, br_taken=1, br_target=8'd15 -> next pc=15. pc=20, skip_taken=1, skip_off=3 -> next pc=24.
- PROGRAM=3, pc=19, call_idx=1 -> pc=sub_addr(1), depth=1; later ret -> pc=20, depth=0. call and br_taken together -> call wins.
- Five nested calls with STACK_DEPTH=4 -> fifth gives FAULT, fault_code=01, pc frozen. ret at depth 0 -> fault_code=10.
- pc=1023 sequential -> pc=0. stall held for 3 cycles at pc=40 -> pc stays 40; br_taken during stall is ignored.
- halt at pc=50 -> halted=1, pc stays 50 and start is ignored. rst_n low mid-call (depth=2) -> pc=0, depth=0, IDLE next edge. With FETCH_PERF_EN, instr_cnt excludes stalled cycles.
